// File: rtl/gpac_adc_capture_if.sv
// Readout FIFO write port: the capture sequencer drives write/data and observes full.
interface gpac_adc_capture_if;
  logic        FIFO_FULL;
  logic        FIFO_WRITE;
  logic [31:0] FIFO_DATA;

  modport master (input FIFO_FULL, output FIFO_WRITE, output FIFO_DATA);
  modport slave  (output FIFO_FULL, input FIFO_WRITE, input FIFO_DATA);
endinterface

// File: rtl/gpac_adc_capture_ctrl.sv
// ADC capture sequencer: arm on START, optional trigger wait, capture a counted
// run of samples from one channel into tagged 32-bit FIFO words.
module gpac_adc_capture_ctrl #(
  parameter int CNT_WIDTH  = 24,
  parameter int LOST_WIDTH = 8
) (
  input  logic                  ADC_ENC,
  input  logic                  ADC_RST_N,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic                  TRIG_EN,
  input  logic                  TRIGGER_IN,
  input  logic [CNT_WIDTH-1:0]  DATA_CNT,
  input  logic [1:0]            DATA_SEL,
  input  logic [13:0]           ADC_IN0,
  input  logic [13:0]           ADC_IN1,
  input  logic [13:0]           ADC_IN2,
  input  logic [13:0]           ADC_IN3,
  gpac_adc_capture_if.master    fifo,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [LOST_WIDTH-1:0] LOST_CNT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  load;
  logic                  cap_p0;
  logic                  last_p0;
  logic                  trig_prev;
  logic                  trig_edge;
  logic [CNT_WIDTH-1:0]  cnt_lat;
  logic [1:0]            sel_lat;
  logic [CNT_WIDTH-1:0]  idx;
  logic [13:0]           sample_p0;
  logic [LOST_WIDTH-1:0] lost;
  logic                  vld_p1;
  logic                  done_p1;
  logic [31:0]           data_p1;

  function automatic logic [LOST_WIDTH-1:0] sat_inc(input logic [LOST_WIDTH-1:0] v);
    return (&v) ? v : v + LOST_WIDTH'(1);
  endfunction

  assign trig_edge = TRIGGER_IN & ~trig_prev;

  always_comb begin
    case (sel_lat)
      2'd0:    sample_p0 = ADC_IN0;
      2'd1:    sample_p0 = ADC_IN1;
      2'd2:    sample_p0 = ADC_IN2;
      default: sample_p0 = ADC_IN3;
    endcase
  end

  always_ff @(posedge ADC_ENC) begin
    if (!ADC_RST_N) state <= IDLE;
    else            state <= state_nxt;
  end

  // ABORT outranks both the trigger and the sample in the same cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cap_p0    = 1'b0;
    last_p0   = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = TRIG_EN ? WAIT_TRIG : CAPTURE;
        end
      end
      WAIT_TRIG: begin
        if (ABORT)          state_nxt = IDLE;
        else if (trig_edge) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (ABORT) begin
          state_nxt = IDLE;
        end else begin
          cap_p0 = 1'b1;
          if (cnt_lat != '0 && idx == cnt_lat - CNT_WIDTH'(1)) begin
            last_p0   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge detector history runs every cycle so a level held across START is not an edge.
  always_ff @(posedge ADC_ENC) begin
    trig_prev <= TRIGGER_IN;
  end

  // Stage p0 -> p1: sample consumed, output word registered.
  always_ff @(posedge ADC_ENC) begin
    if (!ADC_RST_N) begin
      cnt_lat <= '0;
      sel_lat <= '0;
      idx     <= '0;
      lost    <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= cap_p0 & ~fifo.FIFO_FULL;
      done_p1 <= last_p0;
      if (load) begin
        cnt_lat <= DATA_CNT;
        sel_lat <= DATA_SEL;
        idx     <= '0;
        lost    <= '0;
      end
      if (cap_p0) begin
        idx <= idx + CNT_WIDTH'(1);
        if (fifo.FIFO_FULL) lost <= sat_inc(lost);
        else data_p1 <= {sel_lat, (idx == '0), idx[14:0], sample_p0};
      end
    end
  end

  assign fifo.FIFO_WRITE = vld_p1;
  assign fifo.FIFO_DATA  = data_p1;
  assign BUSY            = (state != IDLE);
  assign DONE            = done_p1;
  assign LOST_CNT        = lost;

endmodule

// File: tb/tb_gpac_adc_capture_ctrl.sv
// Scoreboard bench for gpac_adc_capture_ctrl: expected words queued as samples are driven.
module tb_gpac_adc_capture_ctrl;
  localparam int CNT_WIDTH  = 24;
  localparam int LOST_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic                  trig_en = 1'b0;
  logic                  trig_in = 1'b0;
  logic [CNT_WIDTH-1:0]  data_cnt = '0;
  logic [1:0]            data_sel = '0;
  logic [13:0]           adc [4];
  logic                  busy;
  logic                  done;
  logic [LOST_WIDTH-1:0] lost;

  gpac_adc_capture_if fifo_if();

  gpac_adc_capture_ctrl #(.CNT_WIDTH(CNT_WIDTH), .LOST_WIDTH(LOST_WIDTH)) dut (
    .ADC_ENC    (clk),
    .ADC_RST_N  (rst_n),
    .START      (start),
    .ABORT      (abort),
    .TRIG_EN    (trig_en),
    .TRIGGER_IN (trig_in),
    .DATA_CNT   (data_cnt),
    .DATA_SEL   (data_sel),
    .ADC_IN0    (adc[0]),
    .ADC_IN1    (adc[1]),
    .ADC_IN2    (adc[2]),
    .ADC_IN3    (adc[3]),
    .fifo       (fifo_if),
    .BUSY       (busy),
    .DONE       (done),
    .LOST_CNT   (lost)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          n_done = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input logic [1:0] sel, input int idx, input logic [13:0] s);
    return {sel, (idx == 0), 15'(idx), s};
  endfunction

  always @(negedge clk) begin
    if (fifo_if.FIFO_WRITE === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 32'd1);
      else                   chk("fifo_data", fifo_if.FIFO_DATA, exp_q.pop_front());
    end
    if (done === 1'b1) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t1_exp [4] = '{32'hA0000064, 32'h80004065, 32'h80008066, 32'h8000C067};
  int wr0, dn0;

  initial begin
    for (int i = 0; i < 4; i++) adc[i] = '0;
    fifo_if.FIFO_FULL = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_write", 32'(fifo_if.FIFO_WRITE), 32'd0);
    chk("rst_data", fifo_if.FIFO_DATA, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lost", 32'(lost), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Plain 4-sample capture from channel 2
    wr0 = n_wr;
    data_cnt = 4; data_sel = 2; trig_en = 0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      adc[2] = 14'(100 + k);
      adc[0] = 14'($urandom);
      exp_q.push_back(t1_exp[k]);
      @(negedge clk);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);
    tick();
    chk("t1_writes", 32'(n_wr - wr0), 32'd4);

    // Triggered capture; trigger already high at START must not count
    wr0 = n_wr;
    trig_in = 1;
    tick(); tick();
    data_cnt = 2; data_sel = 1; trig_en = 1; start = 1;
    tick();
    start = 0;
    repeat (20) tick();
    chk("t2_wait_busy", 32'(busy), 32'd1);
    chk("t2_no_writes", 32'(n_wr - wr0), 32'd0);
    trig_in = 0;
    tick();
    trig_in = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      adc[1] = 14'($urandom);
      exp_q.push_back(mk_word(2'd1, k, adc[1]));
      tick();
    end
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    tick();
    trig_in = 0;
    tick();
    chk("t2_writes", 32'(n_wr - wr0), 32'd2);

    // Back-pressure on indices 3..4
    wr0 = n_wr;
    data_cnt = 8; data_sel = 3; trig_en = 0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 8; k++) begin
      adc[3] = 14'($urandom);
      fifo_if.FIFO_FULL = (k == 3 || k == 4);
      if (k != 3 && k != 4) exp_q.push_back(mk_word(2'd3, k, adc[3]));
      tick();
    end
    fifo_if.FIFO_FULL = 0;
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_lost", 32'(lost), 32'd2);
    tick(); tick();
    chk("t3_writes", 32'(n_wr - wr0), 32'd6);

    // Continuous mode, START ignored mid-run, ABORT after 40 samples
    wr0 = n_wr; dn0 = n_done;
    data_cnt = 0; data_sel = 0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 40; k++) begin
      adc[0] = 14'($urandom);
      start = (k == 10);
      if (k == 10) begin data_sel = 3; data_cnt = 5; end
      exp_q.push_back(mk_word(2'd0, k, adc[0]));
      tick();
    end
    start = 0;
    chk("t4_lost_cleared", 32'(lost), 32'd0);
    abort = 1;
    adc[0] = 14'($urandom);
    tick();
    abort = 0;
    @(negedge clk);
    chk("t4_busy_after_abort", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("t4_writes", 32'(n_wr - wr0), 32'd40);
    chk("t4_no_done", 32'(n_done - dn0), 32'd0);

    // LOST_CNT saturation
    wr0 = n_wr;
    data_cnt = 0; data_sel = 2; fifo_if.FIFO_FULL = 1; start = 1;
    tick();
    start = 0;
    repeat (300) tick();
    chk("t5_lost_sat", 32'(lost), 32'd255);
    chk("t5_no_writes", 32'(n_wr - wr0), 32'd0);
    abort = 1;
    tick();
    abort = 0;
    fifo_if.FIFO_FULL = 0;
    tick();

    // Reset mid-capture
    data_cnt = 0; data_sel = 2; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      adc[2] = 14'($urandom);
      fifo_if.FIFO_FULL = (k == 2);
      if (k != 2) exp_q.push_back(mk_word(2'd2, k, adc[2]));
      tick();
    end
    fifo_if.FIFO_FULL = 0;
    rst_n = 0;
    @(negedge clk);
    chk("t6_lost_before_rst", 32'(lost), 32'd1);
    tick();
    @(negedge clk);
    chk("t6_rst_write", 32'(fifo_if.FIFO_WRITE), 32'd0);
    chk("t6_rst_data", fifo_if.FIFO_DATA, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_lost", 32'(lost), 32'd0);
    tick();
    rst_n = 1;
    wr0 = n_wr;
    repeat (5) tick();
    chk("t6_idle_no_writes", 32'(n_wr - wr0), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
